// File: rtl/seq_adder_pkg.sv
// Shared types and sizing helpers for the multi-cycle chunked adder.
// Optional build macro used by the design: SEQ_ADDER_OVF_EN.
package seq_adder_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Number of chunk additions needed to cover the full operand width.
    function automatic int calc_nstep(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Step counter width; a single-step adder still keeps a 1-bit counter.
    function automatic int calc_step_w(input int nstep);
        return (nstep <= 1) ? 1 : $clog2(nstep);
    endfunction

endpackage

// File: rtl/fulladder_chunk.sv
// Combinational CHUNK-bit ripple adder made of 1-bit full-adder cells.
// With SEQ_ADDER_OVF_EN defined it also exposes the carry into the MSB cell.
module fulladder_chunk #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] s_o,
`ifdef SEQ_ADDER_OVF_EN
    output logic             c_msb_o,
`endif
    output logic             cout_o
);

    logic [CHUNK:0] c;

    // NOTE: combinational logic uses blocking '=' so each cell sees the carry
    // produced by the cell below it within the same evaluation.
    always_comb begin
        c    = '0;
        s_o  = '0;
        c[0] = cin_i;
        for (int i = 0; i < CHUNK; i++) begin
            s_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]  = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_o = c[CHUNK];

`ifdef SEQ_ADDER_OVF_EN
    assign c_msb_o = c[CHUNK-1];
`endif

endmodule

// File: rtl/seq_adder_nbit.sv
// Multi-cycle adder: x1 + x2 + ripin, CHUNK bits per clock through a registered carry.
// Defining SEQ_ADDER_OVF_EN adds the two's-complement overflow output ovf.
module seq_adder_nbit
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic             ripin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] somma,
`ifdef SEQ_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             ripout
);

    localparam int NSTEP = calc_nstep(WIDTH, CHUNK);
    localparam int SW    = calc_step_w(NSTEP);
    localparam logic [SW-1:0] LAST_STEP = SW'(NSTEP - 1);
    localparam logic [SW-1:0] STEP_ONE  = SW'(1);

    state_e           state_q, state_d;
    logic [SW-1:0]    step_q, step_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] somma_q, somma_d;
    logic             ripout_q, ripout_d;
    logic             done_q, done_d;

    logic [CHUNK-1:0] chunk_a, chunk_b, chunk_s;
    logic             chunk_cout;
    int               chunk_base;

    assign chunk_base = int'(step_q) * CHUNK;
    assign chunk_a    = a_q[chunk_base +: CHUNK];
    assign chunk_b    = b_q[chunk_base +: CHUNK];

`ifdef SEQ_ADDER_OVF_EN
    logic chunk_c_msb;
    logic ovf_q, ovf_d;
`endif

    fulladder_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_i     (chunk_a),
        .b_i     (chunk_b),
        .cin_i   (carry_q),
        .s_o     (chunk_s),
`ifdef SEQ_ADDER_OVF_EN
        .c_msb_o (chunk_c_msb),
`endif
        .cout_o  (chunk_cout)
    );

    // NOTE: every variable gets its hold value first, so no path through the
    // case statement leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        psum_d   = psum_q;
        somma_d  = somma_q;
        ripout_d = ripout_q;
        done_d   = 1'b0;
`ifdef SEQ_ADDER_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = x1;
                    b_d     = x2;
                    carry_d = ripin;
                    step_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                psum_d[chunk_base +: CHUNK] = chunk_s;
                carry_d = chunk_cout;
                step_d  = step_q + STEP_ONE;
                // The last chunk holds the MSB, so its carries are the final ones.
                if (step_q == LAST_STEP) begin
                    somma_d  = psum_d;
                    ripout_d = chunk_cout;
`ifdef SEQ_ADDER_OVF_EN
                    ovf_d    = chunk_c_msb ^ chunk_cout;
`endif
                    done_d   = 1'b1;
                    step_d   = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the operand and partial-sum registers are plain flops, not a
    // memory array, so they are reset along with the control state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            step_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            psum_q   <= '0;
            somma_q  <= '0;
            ripout_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            psum_q   <= psum_d;
            somma_q  <= somma_d;
            ripout_q <= ripout_d;
            done_q   <= done_d;
        end
    end

`ifdef SEQ_ADDER_OVF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy   = (state_q == RUN);
    assign done   = done_q;
    assign somma  = somma_q;
    assign ripout = ripout_q;

endmodule

// File: tb/tb_seq_adder_nbit.sv
// Self-checking bench: four adders (CHUNK = 1, 2, 4, 8) driven in parallel and
// compared against plain integer arithmetic and a cycle-count timing model.
module tb_seq_adder_nbit;

    localparam int W  = 8;
    localparam int NI = 4;

    logic           clk;
    logic           reset;
    logic           start;
    logic           ripin;
    logic [W-1:0]   x1, x2;
    logic [NI-1:0]  busy_w, done_w, ripout_w;
    logic [W-1:0]   somma_w [NI];
`ifdef SEQ_ADDER_OVF_EN
    logic [NI-1:0]  ovf_w;
`endif

    int checks;
    int failures;

    // Last completed result expected on each instance's held outputs.
    logic [W-1:0] exp_sum  [NI];
    logic         exp_cout [NI];
    logic         exp_ovf  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        seq_adder_nbit #(
            .WIDTH (W),
            .CHUNK (1 << g)
        ) u_dut (
            .clk    (clk),
            .reset  (reset),
            .start  (start),
            .x1     (x1),
            .x2     (x2),
            .ripin  (ripin),
            .busy   (busy_w[g]),
            .done   (done_w[g]),
            .somma  (somma_w[g]),
`ifdef SEQ_ADDER_OVF_EN
            .ovf    (ovf_w[g]),
`endif
            .ripout (ripout_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int nstep_of(input int i);
        return W >> i;
    endfunction

    // Compare all held outputs of every instance against the given expectations.
    task automatic check_outputs(input string ctx, input int i, input logic exp_busy,
                                 input logic exp_done, input logic [W-1:0] s,
                                 input logic co, input logic ov);
        string pfx;
        pfx = $sformatf("%s.c%0d", ctx, 1 << i);
        check({pfx, ".busy"},   32'(busy_w[i]),   32'(exp_busy));
        check({pfx, ".done"},   32'(done_w[i]),   32'(exp_done));
        check({pfx, ".somma"},  32'(somma_w[i]),  32'(s));
        check({pfx, ".ripout"}, 32'(ripout_w[i]), 32'(co));
`ifdef SEQ_ADDER_OVF_EN
        check({pfx, ".ovf"},    32'(ovf_w[i]),    32'(ov));
`else
        if (ov === 1'bx) $display("unexpected x in ovf model");
`endif
    endtask

    // Reference: unsigned sum with carry out, and signed range test for overflow.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         output logic [W-1:0] s, output logic co, output logic ov);
        logic [W:0] full;
        int         sgn;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        sgn  = int'($signed(a)) + int'($signed(b)) + int'(c);
        s    = full[W-1:0];
        co   = full[W];
        ov   = (sgn > ((1 << (W - 1)) - 1)) || (sgn < -(1 << (W - 1)));
    endtask

    // One start pulse; optionally disturb inputs and re-pulse start while busy.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input bit disturb);
        logic [W-1:0] s;
        logic         co, ov;
        model(a, b, c, s, co, ov);
        @(negedge clk);
        x1 = a; x2 = b; ripin = c; start = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= W + 1; k++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (k >= nstep_of(i))
                    check_outputs("op", i, k < nstep_of(i), k == nstep_of(i), s, co, ov);
                else
                    check_outputs("op", i, 1'b1, 1'b0, exp_sum[i], exp_cout[i], exp_ovf[i]);
            end
            if (k == 0 && disturb) begin
                x1 = ~a; x2 = a ^ 8'h5A; ripin = ~c; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        for (int i = 0; i < NI; i++) begin
            exp_sum[i] = s; exp_cout[i] = co; exp_ovf[i] = ov;
        end
    endtask

    // start held high: each instance restarts in its done cycle, period NSTEP+1.
    task automatic run_stream(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                              input int len);
        logic [W-1:0] s;
        logic         co, ov;
        int           ph;
        model(a, b, c, s, co, ov);
        @(negedge clk);
        x1 = a; x2 = b; ripin = c; start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                ph = k % (nstep_of(i) + 1);
                if (k >= nstep_of(i))
                    check_outputs("stream", i, ph < nstep_of(i), ph == nstep_of(i), s, co, ov);
                else
                    check_outputs("stream", i, 1'b1, 1'b0, exp_sum[i], exp_cout[i], exp_ovf[i]);
            end
        end
        start = 1'b0;
        repeat (W + 2) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            exp_sum[i] = s; exp_cout[i] = co; exp_ovf[i] = ov;
        end
    endtask

    // Reset asserted asynchronously in the second RUN cycle; no done may follow.
    task automatic reset_mid_run(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        x1 = a; x2 = b; ripin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            exp_sum[i] = '0; exp_cout[i] = 1'b0; exp_ovf[i] = 1'b0;
            check_outputs("rst_async", i, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < W + 2; k++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++)
                check_outputs("rst_quiet", i, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        ripin    = 1'b0;
        x1       = '0;
        x2       = '0;
        for (int i = 0; i < NI; i++) begin
            exp_sum[i] = '0; exp_cout[i] = 1'b0; exp_ovf[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++)
            check_outputs("reset", i, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        reset = 1'b0;

        run_op(8'h01, 8'h02, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0);
        run_op(8'h80, 8'h80, 1'b0, 1'b0);
        run_op(8'h01, 8'h02, 1'b0, 1'b0);
        run_op(8'h10, 8'h20, 1'b0, 1'b1);
        reset_mid_run(8'hA5, 8'h3C);
        run_op(8'h33, 8'h44, 1'b1, 1'b0);
        run_stream(8'hC3, 8'h5E, 1'b1, 3 * (W + 1));

        for (int n = 0; n < 40; n++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
